// File: rtl/commit_store_buffer_pkg.sv
// Shared types for the commit store buffer: store entry layout and drain FSM states.
package commit_store_buffer_pkg;

  localparam int unsigned ADDR_W = 56;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } store_entry_t;

  typedef enum logic {
    DRAIN_IDLE,
    DRAIN_REQ
  } drain_state_e;

endpackage

// File: rtl/commit_store_buffer_if.sv
// Store-unit, commit-stage and D$ write-port signals of the commit store buffer.
interface commit_store_buffer_if;
  import commit_store_buffer_pkg::*;

  logic              flush_i;
  logic              st_valid_i;
  logic              st_ready_o;
  logic [ADDR_W-1:0] st_addr_i;
  logic [DATA_W-1:0] st_data_i;
  logic [BE_W-1:0]   st_be_i;
  logic              commit_lsu_i;
  logic              commit_lsu_ready_o;
  logic              no_st_pending_o;
  logic              dc_req_o;
  logic [ADDR_W-1:0] dc_addr_o;
  logic [DATA_W-1:0] dc_data_o;
  logic [BE_W-1:0]   dc_be_o;
  logic              dc_gnt_i;

  modport slave (
    input  flush_i, st_valid_i, st_addr_i, st_data_i, st_be_i, commit_lsu_i, dc_gnt_i,
    output st_ready_o, commit_lsu_ready_o, no_st_pending_o, dc_req_o, dc_addr_o, dc_data_o, dc_be_o
  );

  modport master (
    output flush_i, st_valid_i, st_addr_i, st_data_i, st_be_i, commit_lsu_i, dc_gnt_i,
    input  st_ready_o, commit_lsu_ready_o, no_st_pending_o, dc_req_o, dc_addr_o, dc_data_o, dc_be_o
  );

endinterface

// File: rtl/commit_store_buffer_sync_fifo_cnt.sv
// Generic circular FIFO with an occupancy count and a synchronous flush.
module commit_store_buffer_sync_fifo_cnt #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  T                 push_data_i,
  input  logic             pop_i,
  output T                 head_o,
  output logic [CNT_W-1:0] count_o
);

  T                 mem_q [DEPTH];
  T                 mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Count-based full/empty; pointers wrap naturally because DEPTH is a power of 2.
  // A flush wins over a same-cycle push but still lets the pop read the current head.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push_i && (count_q != CNT_W'(DEPTH));
    do_pop   = pop_i && (count_q != '0);

    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/commit_store_buffer.sv
// LSU store buffer: speculative FIFO, committed FIFO and a req/gnt drain to the D$ write port.
module commit_store_buffer
  import commit_store_buffer_pkg::*;
#(
  parameter int unsigned SPEC_DEPTH   = 4,
  parameter int unsigned COMMIT_DEPTH = 8
) (
  input logic                  clk_i,
  input logic                  rst_i,
  commit_store_buffer_if.slave bus
);

  localparam int unsigned SPEC_CNT_W   = $clog2(SPEC_DEPTH + 1);
  localparam int unsigned COMMIT_CNT_W = $clog2(COMMIT_DEPTH + 1);

  store_entry_t            st_entry;
  store_entry_t            spec_head;
  store_entry_t            commit_head;
  logic [SPEC_CNT_W-1:0]   spec_count;
  logic [COMMIT_CNT_W-1:0] commit_count;
  logic                    spec_empty;
  logic                    spec_full;
  logic                    commit_empty;
  logic                    commit_full;
  logic                    commit_fire;
  logic                    drain_pop;

  drain_state_e state_q, state_d;
  store_entry_t dc_entry_q, dc_entry_d;

  assign st_entry     = '{addr: bus.st_addr_i, data: bus.st_data_i, be: bus.st_be_i};
  assign spec_empty   = (spec_count == '0);
  assign spec_full    = (spec_count == SPEC_CNT_W'(SPEC_DEPTH));
  assign commit_empty = (commit_count == '0);
  assign commit_full  = (commit_count == COMMIT_CNT_W'(COMMIT_DEPTH));
  assign commit_fire  = bus.commit_lsu_i && !spec_empty && !commit_full;

  commit_store_buffer_sync_fifo_cnt #(
    .DEPTH (SPEC_DEPTH),
    .T     (store_entry_t)
  ) u_spec_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (bus.flush_i),
    .push_i      (bus.st_valid_i),
    .push_data_i (st_entry),
    .pop_i       (commit_fire),
    .head_o      (spec_head),
    .count_o     (spec_count)
  );

  commit_store_buffer_sync_fifo_cnt #(
    .DEPTH (COMMIT_DEPTH),
    .T     (store_entry_t)
  ) u_commit_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (1'b0),
    .push_i      (commit_fire),
    .push_data_i (spec_head),
    .pop_i       (drain_pop),
    .head_o      (commit_head),
    .count_o     (commit_count)
  );

  // The request payload is latched when entering REQ so it stays stable until grant.
  // Every granted store passes through IDLE once, giving one store per two cycles.
  always_comb begin
    state_d    = state_q;
    dc_entry_d = dc_entry_q;
    drain_pop  = 1'b0;

    case (state_q)
      DRAIN_IDLE: begin
        if (!commit_empty) begin
          state_d    = DRAIN_REQ;
          dc_entry_d = commit_head;
        end
      end
      DRAIN_REQ: begin
        if (bus.dc_gnt_i) begin
          drain_pop  = 1'b1;
          state_d    = DRAIN_IDLE;
          dc_entry_d = '0;
        end
      end
      default: begin
        state_d    = DRAIN_IDLE;
        dc_entry_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= DRAIN_IDLE;
      dc_entry_q <= '0;
    end else begin
      state_q    <= state_d;
      dc_entry_q <= dc_entry_d;
    end
  end

  assign bus.st_ready_o         = !spec_full;
  assign bus.commit_lsu_ready_o = !commit_full;
  assign bus.no_st_pending_o    = spec_empty && commit_empty && (state_q == DRAIN_IDLE);
  assign bus.dc_req_o           = (state_q == DRAIN_REQ);
  assign bus.dc_addr_o          = dc_entry_q.addr;
  assign bus.dc_data_o          = dc_entry_q.data;
  assign bus.dc_be_o            = dc_entry_q.be;

  // The commit stage must only commit an existing store into a FIFO with room.
  a_commit_legal: assert property (@(posedge clk_i) disable iff (rst_i)
    bus.commit_lsu_i |-> (!spec_empty && !commit_full));

endmodule

// File: tb/tb_commit_store_buffer.sv
// Scoreboard bench for commit_store_buffer: models both FIFOs and checks every D$ request.
module tb_commit_store_buffer;
  import commit_store_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  commit_store_buffer_if bus();

  commit_store_buffer #(
    .SPEC_DEPTH   (4),
    .COMMIT_DEPTH (8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int           checks      = 0;
  int           errors      = 0;
  int           drain_count = 0;
  bit           gnt_enable  = 1'b0;
  int unsigned  st_seq      = 0;
  store_entry_t spec_model[$];
  store_entry_t exp_q[$];
  store_entry_t no_store;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic store_entry_t makeStore();
    store_entry_t e;
    e.addr = 56'h8000_2000 + ADDR_W'(st_seq * 8);
    e.data = {$urandom, $urandom};
    e.be   = 8'($urandom_range(255, 1));
    st_seq++;
    return e;
  endfunction

  // Drives one cycle of stimulus and updates the reference model the same way the DUT should.
  task automatic applyStimulus(input logic valid, input store_entry_t st, input logic commit, input logic flush);
    bit accept;
    bus.st_valid_i   = valid;
    bus.st_addr_i    = st.addr;
    bus.st_data_i    = st.data;
    bus.st_be_i      = st.be;
    bus.commit_lsu_i = commit;
    bus.flush_i      = flush;
    accept = valid && !flush && (spec_model.size() < 4);
    if (commit && spec_model.size() > 0) exp_q.push_back(spec_model.pop_front());
    if (flush) spec_model.delete();
    if (accept) spec_model.push_back(st);
    @(posedge clk);
    #1;
    bus.st_valid_i   = 1'b0;
    bus.commit_lsu_i = 1'b0;
    bus.flush_i      = 1'b0;
  endtask

  task automatic waitDrained(input string tag, input int max_cycles);
    int n = 0;
    while ((exp_q.size() != 0 || (spec_model.size() == 0 && !bus.no_st_pending_o)) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_timeout"}, 64'(n >= max_cycles), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic waitReq(input string tag, input int max_cycles);
    int n = 0;
    while (!bus.dc_req_o && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_timeout"}, 64'(n >= max_cycles), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Grant follows an open request when enabled, driven just after the clock edge.
  initial begin
    bus.dc_gnt_i = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.dc_gnt_i = gnt_enable && bus.dc_req_o;
    end
  end

  // Every open request must carry the oldest committed store; a grant retires it.
  always @(negedge clk) begin
    if (!rst && bus.dc_req_o) begin
      if (exp_q.size() == 0) begin
        checkOutput("dc_req_without_store", 64'd1, 64'd0);
      end else begin
        checkOutput("dc_addr", 64'(bus.dc_addr_o), 64'(exp_q[0].addr));
        checkOutput("dc_data", bus.dc_data_o, exp_q[0].data);
        checkOutput("dc_be", 64'(bus.dc_be_o), 64'(exp_q[0].be));
        if (bus.dc_gnt_i) begin
          void'(exp_q.pop_front());
          drain_count++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    store_entry_t first;
    int base;
    int n;
    no_store         = '0;
    rst              = 1'b1;
    bus.flush_i      = 1'b0;
    bus.st_valid_i   = 1'b0;
    bus.st_addr_i    = '0;
    bus.st_data_i    = '0;
    bus.st_be_i      = '0;
    bus.commit_lsu_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_st_ready", 64'(bus.st_ready_o), 64'd1);
    checkOutput("rst_commit_ready", 64'(bus.commit_lsu_ready_o), 64'd1);
    checkOutput("rst_no_pending", 64'(bus.no_st_pending_o), 64'd1);
    checkOutput("rst_dc_req", 64'(bus.dc_req_o), 64'd0);
    checkOutput("rst_dc_addr", 64'(bus.dc_addr_o), 64'd0);
    checkOutput("rst_dc_data", bus.dc_data_o, 64'd0);
    checkOutput("rst_dc_be", 64'(bus.dc_be_o), 64'd0);
    @(posedge clk);
    #1;

    $display("[TB] single store");
    gnt_enable = 1'b1;
    first = '{addr: 56'h8000_1000, data: 64'h0000_0000_DEAD_BEEF, be: 8'h0F};
    applyStimulus(1'b1, first, 1'b0, 1'b0);
    applyStimulus(1'b0, no_store, 1'b1, 1'b0);
    n = 0;
    while (!(bus.dc_req_o && bus.dc_gnt_i) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("single_gnt_timeout", 64'(n >= 20), 64'd0);
    checkOutput("single_addr", 64'(bus.dc_addr_o), 64'h8000_1000);
    checkOutput("single_data", bus.dc_data_o, 64'hDEAD_BEEF);
    checkOutput("single_be", 64'(bus.dc_be_o), 64'h0F);
    @(negedge clk);
    checkOutput("single_no_pending", 64'(bus.no_st_pending_o), 64'd1);
    checkOutput("single_req_low", 64'(bus.dc_req_o), 64'd0);
    @(posedge clk);
    #1;

    $display("[TB] fill speculative FIFO");
    gnt_enable = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, makeStore(), 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("full_st_ready", 64'(bus.st_ready_o), 64'd0);
    checkOutput("full_spec_count", 64'(dut.spec_count), 64'd4);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, makeStore(), 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("full_push_dropped", 64'(dut.spec_count), 64'd4);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, no_store, 1'b1, 1'b0);
    applyStimulus(1'b1, makeStore(), 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("push_commit_spec_count", 64'(dut.spec_count), 64'd3);
    checkOutput("push_commit_st_ready", 64'(bus.st_ready_o), 64'd1);
    checkOutput("push_commit_commit_count", 64'(dut.commit_count), 64'd2);
    @(posedge clk);
    #1;

    $display("[TB] fill committed FIFO with grant held low");
    while (exp_q.size() < 8) applyStimulus(1'b1, makeStore(), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("hold_commit_ready", 64'(bus.commit_lsu_ready_o), 64'd0);
      checkOutput("hold_dc_req", 64'(bus.dc_req_o), 64'd1);
      checkOutput("hold_dc_addr", 64'(bus.dc_addr_o), 64'(exp_q[0].addr));
    end
    checkOutput("hold_commit_count", 64'(dut.commit_count), 64'd8);
    checkOutput("hold_spec_count", 64'(dut.spec_count), 64'd3);
    @(posedge clk);
    #1;
    gnt_enable = 1'b1;
    waitDrained("wrap_drain", 100);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, no_store, 1'b1, 1'b0);
    waitDrained("tail_drain", 100);
    checkOutput("tail_no_pending", 64'(bus.no_st_pending_o), 64'd1);

    $display("[TB] flush with commit");
    gnt_enable = 1'b0;
    applyStimulus(1'b1, makeStore(), 1'b0, 1'b0);
    applyStimulus(1'b0, no_store, 1'b1, 1'b0);
    waitReq("flush_req", 20);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, makeStore(), 1'b0, 1'b0);
    applyStimulus(1'b1, makeStore(), 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("flush_spec_count", 64'(dut.spec_count), 64'd0);
    checkOutput("flush_commit_count", 64'(dut.commit_count), 64'd2);
    checkOutput("flush_dc_req_open", 64'(bus.dc_req_o), 64'd1);
    checkOutput("flush_st_ready", 64'(bus.st_ready_o), 64'd1);
    base = drain_count;
    @(posedge clk);
    #1;
    gnt_enable = 1'b1;
    waitDrained("flush_drain", 50);
    checkOutput("flush_drained_stores", 64'(drain_count - base), 64'd2);
    checkOutput("flush_no_pending", 64'(bus.no_st_pending_o), 64'd1);

    $display("[TB] reset during request");
    gnt_enable = 1'b0;
    applyStimulus(1'b1, makeStore(), 1'b0, 1'b0);
    applyStimulus(1'b1, makeStore(), 1'b1, 1'b0);
    waitReq("rst_req", 20);
    rst = 1'b1;
    spec_model.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_dc_req", 64'(bus.dc_req_o), 64'd0);
    checkOutput("midrst_spec_count", 64'(dut.spec_count), 64'd0);
    checkOutput("midrst_commit_count", 64'(dut.commit_count), 64'd0);
    checkOutput("midrst_no_pending", 64'(bus.no_st_pending_o), 64'd1);
    checkOutput("midrst_commit_ready", 64'(bus.commit_lsu_ready_o), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
